// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide unit for the EX stage.
// Radix-2 shift-add multiply, restoring divide, one iteration per cycle.
// Optional feature macro: MDU_KILL_EN (adds a kill input for pipeline flush).
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   kill       (MDU_KILL_EN only) abandon the operation in CALC/FIX
//   start      launch an operation; sampled only when not busy
//   op         0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//   operand_a  rs1 value from the forwarding mux
//   operand_b  rs2 value from the forwarding mux
//   busy       high in CALC and FIX
//   done       one-cycle pulse when result becomes valid
//   result     last result, held until the next completion
//
// state | meaning
// IDLE  | waiting for start
// CALC  | one multiply/divide iteration per cycle
// FIX   | sign correction and result select
// DONE  | done pulse; may accept a back-to-back start

`ifndef INTERNAL_BITS
`define INTERNAL_BITS 32
`endif

module mul_div_unit #(
  parameter int WIDTH = `INTERNAL_BITS,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef MDU_KILL_EN
  input  logic             kill,
`endif
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  logic             neg_q;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;

  logic kill_req;
`ifdef MDU_KILL_EN
  assign kill_req = kill;
`else
  assign kill_req = 1'b0;
`endif

  // Operand conditioning at accept
  logic             a_signed, b_signed, sign_a, sign_b, neg_in;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             div_zero, div_ovf, special;
  logic [WIDTH-1:0] special_res;
  logic             accept;

  assign a_signed = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
  assign b_signed = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
  assign sign_a   = a_signed & operand_a[WIDTH-1];
  assign sign_b   = b_signed & operand_b[WIDTH-1];
  assign a_mag    = sign_a ? -operand_a : operand_a;
  assign b_mag    = sign_b ? -operand_b : operand_b;
  // Remainder follows the dividend; product and quotient follow the sign xor.
  assign neg_in   = (op == 3'd6 || op == 3'd7) ? sign_a : (sign_a ^ sign_b);

  assign div_zero = op[2] && (operand_b == '0);
  assign div_ovf  = (op == 3'd4 || op == 3'd6) &&
                    (operand_a == {1'b1, {(WIDTH-1){1'b0}}}) && (operand_b == '1);
  assign special  = div_zero | div_ovf;
  // op[1] separates REM/REMU from DIV/DIVU
  always_comb begin
    special_res = '0;
    if (div_zero)
      special_res = op[1] ? operand_a : '1;
    else if (div_ovf)
      special_res = op[1] ? '0 : operand_a;
  end

  assign accept = start && ((state == S_IDLE) || (state == S_DONE));

  // One iteration of either loop
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ok;
  logic [WIDTH-1:0] div_diff;

  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ok    = (div_shift >= {1'b0, opb});
  // When div_ok the true difference is below opb, so the low word is exact.
  assign div_diff  = div_shift[WIDTH-1:0] - opb;

  // Sign fix and selection
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix, fix_res;

  assign prod_fix = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
  assign quot_fix = neg_q ? -acc_lo : acc_lo;
  assign rem_fix  = neg_q ? -acc_hi : acc_hi;

  always_comb begin
    fix_res = '0;
    case (op_q)
      3'd0:                fix_res = prod_fix[WIDTH-1:0];
      3'd1, 3'd2, 3'd3:    fix_res = prod_fix[2*WIDTH-1:WIDTH];
      3'd4, 3'd5:          fix_res = quot_fix;
      default:             fix_res = rem_fix;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      op_q   <= '0;
      neg_q  <= 1'b0;
      opb    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      result <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            op_q   <= op;
            neg_q  <= neg_in;
            opb    <= b_mag;
            acc_lo <= a_mag;
            acc_hi <= '0;
            cnt    <= CNT_W'(WIDTH);
            if (special) begin
              result <= special_res;
              state  <= S_DONE;
            end else begin
              state  <= S_CALC;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_CALC: begin
          if (kill_req) begin
            state <= S_IDLE;
          end else begin
            if (op_q[2]) begin
              acc_hi <= div_ok ? div_diff : div_shift[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
            end else begin
              {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
            end
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1))
              state <= S_FIX;
          end
        end
        default: begin
          if (kill_req) begin
            state <= S_IDLE;
          end else begin
            result <= fix_res;
            state  <= S_DONE;
          end
        end
      endcase
    end
  end

  assign busy = (state == S_CALC) || (state == S_FIX);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         kill = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = '0;
  logic [W-1:0] operand_a = '0;
  logic [W-1:0] operand_b = '0;
  logic         busy, done;
  logic [W-1:0] result;

  mul_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef MDU_KILL_EN
    .kill(kill),
`endif
    .start(start),
    .op(op),
    .operand_a(operand_a),
    .operand_b(operand_b),
    .busy(busy),
    .done(done),
    .result(result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W-1:0] exp_last = '0;

  // Reference model: plain 64-bit arithmetic following the RV32M rules.
  function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint     sa, sb2, ua, ub;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb2 = longint'($signed(b));
    ua  = longint'({32'b0, a});
    ub  = longint'({32'b0, b});
    case (o)
      3'd0: begin p = 64'(ua * ub);  return p[31:0];  end
      3'd1: begin p = 64'(sa * sb2); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub);  return p[63:32]; end
      3'd3: begin p = 64'(ua * ub);  return p[63:32]; end
      3'd4: begin
        if (b == 0) return '1;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = 64'(sa / sb2); return p[31:0];
      end
      3'd5: begin if (b == 0) return '1; return a / b; end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return '0;
        p = 64'(sa % sb2); return p[31:0];
      end
      default: begin if (b == 0) return a; return a % b; end
    endcase
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: got done with result %h, expected none (cycle %0d)", result, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (result !== e.res) begin
          n_fail++;
          $display("FAIL result: got %h, expected %h (cycle %0d)", result, e.res, cyc);
        end
        n_tests++;
        if (cyc != e.cyc) begin
          n_fail++;
          $display("FAIL latency: done at cycle %0d, expected %0d", cyc, e.cyc);
        end
        exp_last = e.res;
      end
    end
  end

  function automatic bit is_special(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    return o[2] && (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  task automatic push_exp(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input int c0);
    exp_t e;
    e.res = model(o, a, b);
    e.cyc = c0 + (is_special(o, a, b) ? 0 : W + 1);
    sb.push_back(e);
  endtask

  // Called at a negedge; issues one op and waits for its done.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    bit spec, seen;
    spec = is_special(o, a, b);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    push_exp(o, a, b, cyc + 1);
    seen = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 1) begin
        start = 1'b0;
        op = 3'($urandom); operand_a = $urandom; operand_b = $urandom;
        check("busy_after_accept", {31'b0, busy}, {31'b0, !spec});
      end
      if (i == 10 && !spec) check("result_held", result, exp_last);
      if (done) begin seen = 1'b1; break; end
    end
    if (!seen) begin
      n_tests++; n_fail++;
      $display("FAIL timeout: no done for op %0d a=%h b=%h", o, a, b);
    end
    @(negedge clk);
  endtask

  initial begin
    int c0;
    bit seen;
    repeat (2) @(negedge clk);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_result", result, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd5, 32'd100, 32'd7);
    run_op(3'd4, 32'd5, 32'd0);
    run_op(3'd7, 32'd5, 32'd0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Start held while busy is ignored; start in DONE issues back-to-back.
    start = 1'b1; op = 3'd0; operand_a = 32'd3; operand_b = 32'd4;
    c0 = cyc + 1;
    push_exp(3'd0, 32'd3, 32'd4, c0);
    @(negedge clk);
    op = 3'd4; operand_a = 32'd9; operand_b = 32'd3;
    check("b2b_busy_cycle1", {31'b0, busy}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    if (!seen) begin n_tests++; n_fail++; $display("FAIL timeout: b2b first done missing"); end
    check("b2b_busy_in_done", {31'b0, busy}, 32'd0);
    push_exp(3'd4, 32'd9, 32'd3, c0 + W + 2);
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy_after", {31'b0, busy}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    if (!seen) begin n_tests++; n_fail++; $display("FAIL timeout: b2b second done missing"); end
    @(negedge clk);
    run_op(3'd0, 32'd3, 32'd4);

    // Reset mid-operation
    start = 1'b1; op = 3'd0; operand_a = 32'd11; operand_b = 32'd13;
    push_exp(3'd0, 32'd11, 32'd13, cyc + 1);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    void'(sb.pop_back());
    exp_last = '0;
    #1;
    check("midreset_busy", {31'b0, busy}, 32'd0);
    check("midreset_done", {31'b0, done}, 32'd0);
    check("midreset_result", result, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("post_reset_result", result, '0);
    run_op(3'd0, 32'd2, 32'd3);

`ifdef MDU_KILL_EN
    start = 1'b1; op = 3'd5; operand_a = 32'd1000; operand_b = 32'd7;
    push_exp(3'd5, 32'd1000, 32'd7, cyc + 1);
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    kill = 1'b1;
    void'(sb.pop_back());
    @(negedge clk);
    kill = 1'b0;
    check("kill_busy", {31'b0, busy}, 32'd0);
    repeat (40) @(negedge clk);
    check("kill_result_kept", result, exp_last);
    run_op(3'd5, 32'd1000, 32'd7);
`endif

    // Randomized ops
    for (int n = 0; n < 40; n++) begin
      logic [2:0]   ro;
      logic [W-1:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 20));
        default: ;
      endcase
      run_op(ro, ra, rb);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
